if_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipelined CPU, sitting directly upstream of the decode stage. Holds the fetch PC and drives a request/ready instruction-memory port. Buffers one returned instruction while decode is stalled, and loads the IF/ID pipeline register that supplies `pc4` and `inst` to decode. Consumes decode's redirect outputs (`pcsource`, `bpc`, `jpc`, register target) and squashes the wrong-path instruction, so there is no delay slot.

---
 rtl/if_stage.sv | 125 ++++++++++++
 tb/tb_if_stage.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, talks to a request/ready instruction
// memory, buffers one word in a skid register while decode stalls, and loads IF/ID.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        stall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] ra,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic        id_valid
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        SKID = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] redir_pc;
    logic [31:0] skid_pc4;
    logic [31:0] skid_inst;
    logic [31:0] seq_pc;
    logic [31:0] target;
    logic        redir;

    assign seq_pc = fetch_pc + 32'd4;

    // Redirect only acts on a real instruction in IF/ID that decode is not holding.
    assign redir = (pcsource != 2'b00) && !stall && id_valid;

    always_comb begin
        target = seq_pc;
        case (pcsource)
            2'b01:   target = bpc;
            2'b10:   target = ra;
            2'b11:   target = jpc;
            default: target = seq_pc;
        endcase
    end

    // The skid register takes the place of memory while it is full.
    assign imem_req  = (state != SKID);
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= RUN;
            fetch_pc  <= RESET_PC;
            redir_pc  <= 32'd0;
            skid_pc4  <= 32'd0;
            skid_inst <= 32'd0;
            pc4       <= 32'd0;
            inst      <= NOP;
            id_valid  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (redir) begin
                        inst     <= NOP;
                        id_valid <= 1'b0;
                        if (imem_ready) begin
                            fetch_pc <= target;
                        end else begin
                            // Address must stay put until memory answers; remember where to go.
                            redir_pc <= target;
                            state    <= DROP;
                        end
                    end else if (imem_ready) begin
                        fetch_pc <= seq_pc;
                        if (stall) begin
                            skid_pc4  <= seq_pc;
                            skid_inst <= imem_rdata;
                            state     <= SKID;
                        end else begin
                            pc4      <= seq_pc;
                            inst     <= imem_rdata;
                            id_valid <= 1'b1;
                        end
                    end else if (!stall) begin
                        inst     <= NOP;
                        id_valid <= 1'b0;
                    end
                end
                SKID: begin
                    if (!stall) begin
                        state <= RUN;
                        if (redir) begin
                            fetch_pc <= target;
                            inst     <= NOP;
                            id_valid <= 1'b0;
                        end else begin
                            pc4      <= skid_pc4;
                            inst     <= skid_inst;
                            id_valid <= 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (imem_ready) begin
                        fetch_pc <= redir_pc;
                        state    <= RUN;
                    end
                    if (!stall) begin
                        inst     <= NOP;
                        id_valid <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory returns the address as the instruction word,
// consumed IF/ID entries are checked in order against a scoreboard queue.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        clr;
    logic        stall;
    logic [1:0]  pcsource;
    logic [31:0] bpc, jpc, ra;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc4, inst;
    logic        id_valid;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr;

    if_stage dut (
        .clk(clk), .clr(clr), .stall(stall), .pcsource(pcsource),
        .bpc(bpc), .jpc(jpc), .ra(ra),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .pc4(pc4), .inst(inst), .id_valid(id_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] addr);
        exp_q.push_back({addr + 32'd4, addr});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Decode consumes IF/ID whenever it holds a real instruction and is not stalled.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!clr && id_valid && !stall) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL consume: unexpected pc4=%h inst=%h at %0t", pc4, inst, $time);
            end else begin
                e = exp_q.pop_front();
                if ({pc4, inst} !== e)
                    begin
                        errors++;
                        $display("FAIL consume: got pc4=%h inst=%h expected pc4=%h inst=%h at %0t",
                                 pc4, inst, e[63:32], e[31:0], $time);
                    end
            end
        end
    end

    initial begin
        #5000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; stall = 1'b0; pcsource = 2'b00;
        bpc = 32'd0; jpc = 32'd0; ra = 32'd0; imem_ready = 1'b1;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd1);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc4", pc4, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        chk("start_addr", imem_addr, 32'h0);
        push(32'h0); push(32'h4); push(32'h8); push(32'hC); push(32'h10); push(32'h40);

        // streaming
        step(); chk("s1_addr", imem_addr, 32'h4); chk("s1_inst", inst, 32'h0);
                chk("s1_pc4", pc4, 32'h4); chk("s1_valid", {31'd0, id_valid}, 32'd1);
        step(); chk("s2_addr", imem_addr, 32'h8); chk("s2_inst", inst, 32'h4);
        stall = 1'b1;
        // stall with skid capture of @0x8
        step(); chk("k1_req", {31'd0, imem_req}, 32'd0); chk("k1_inst", inst, 32'h4);
                chk("k1_addr", imem_addr, 32'hC);
        step(); chk("k2_req", {31'd0, imem_req}, 32'd0); chk("k2_inst", inst, 32'h4);
        step(); chk("k3_inst", inst, 32'h4); chk("k3_pc4", pc4, 32'h8);
        stall = 1'b0;
        step(); chk("k4_inst", inst, 32'h8); chk("k4_req", {31'd0, imem_req}, 32'd1);
                chk("k4_addr", imem_addr, 32'hC);
        step(); chk("k5_inst", inst, 32'hC); chk("k5_addr", imem_addr, 32'h10);
        step(); chk("k6_inst", inst, 32'h10); chk("k6_addr", imem_addr, 32'h14);
        // branch to 0x40
        pcsource = 2'b01; bpc = 32'h40;
        step(); chk("b1_valid", {31'd0, id_valid}, 32'd0); chk("b1_inst", inst, 32'h0);
                chk("b1_pc4", pc4, 32'h14); chk("b1_addr", imem_addr, 32'h40);
        pcsource = 2'b00;
        step(); chk("b2_inst", inst, 32'h40); chk("b2_pc4", pc4, 32'h44);
                chk("b2_addr", imem_addr, 32'h44);
        // jump while memory is waiting
        push(32'h100);
        imem_ready = 1'b0; pcsource = 2'b11; jpc = 32'h100;
        step(); chk("w1_addr", imem_addr, 32'h44); chk("w1_req", {31'd0, imem_req}, 32'd1);
                chk("w1_valid", {31'd0, id_valid}, 32'd0);
        pcsource = 2'b00;
        step(); chk("w2_addr", imem_addr, 32'h44);
        imem_ready = 1'b1;
        step(); chk("w3_addr", imem_addr, 32'h100); chk("w3_valid", {31'd0, id_valid}, 32'd0);
        step(); chk("w4_inst", inst, 32'h100); chk("w4_pc4", pc4, 32'h104);
                chk("w4_addr", imem_addr, 32'h104);
        // stall overrides register redirect
        push(32'h80);
        stall = 1'b1; pcsource = 2'b10; ra = 32'h80;
        step(); chk("o1_addr", imem_addr, 32'h108); chk("o1_req", {31'd0, imem_req}, 32'd0);
                chk("o1_inst", inst, 32'h100);
        step(); chk("o2_addr", imem_addr, 32'h108); chk("o2_inst", inst, 32'h100);
        stall = 1'b0;
        step(); chk("o3_addr", imem_addr, 32'h80); chk("o3_valid", {31'd0, id_valid}, 32'd0);
                chk("o3_req", {31'd0, imem_req}, 32'd1);
        pcsource = 2'b00;
        step(); chk("o4_inst", inst, 32'h80); chk("o4_addr", imem_addr, 32'h84);
        // async reset while in DROP
        push(32'h0);
        imem_ready = 1'b0; pcsource = 2'b01; bpc = 32'h200;
        step(); chk("d1_addr", imem_addr, 32'h84); chk("d1_valid", {31'd0, id_valid}, 32'd0);
        pcsource = 2'b00;
        #1 clr = 1'b1;
        #1;
        chk("ar_addr", imem_addr, 32'h0); chk("ar_req", {31'd0, imem_req}, 32'd1);
        chk("ar_pc4", pc4, 32'h0); chk("ar_inst", inst, 32'h0);
        chk("ar_valid", {31'd0, id_valid}, 32'd0);
        #1 clr = 1'b0; imem_ready = 1'b1;
        step(); chk("ar2_inst", inst, 32'h0); chk("ar2_pc4", pc4, 32'h4);
                chk("ar2_addr", imem_addr, 32'h4);
        // wrap at the top of the address space
        push(32'hFFFF_FFFC);
        pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
        step(); chk("x1_addr", imem_addr, 32'hFFFF_FFFC);
        pcsource = 2'b00;
        step(); chk("x2_inst", inst, 32'hFFFF_FFFC); chk("x2_pc4", pc4, 32'h0);
                chk("x2_addr", imem_addr, 32'h0);
        step(); chk("x3_inst", inst, 32'h0); chk("x3_pc4", pc4, 32'h4);
        stall = 1'b1;
        step();
        chk("q_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
